// File: rtl/out_port_listener.sv
// Receiving end of the processor output port: buffers each outSignalEn word in a
// small first-word-fall-through FIFO and drains it over valid/ready, counting drops.
module out_port_listener #(
    parameter int DATA_WIDTH = 16,
    parameter int DEPTH      = 8,
    parameter int ADDR_W     = 3
) (
    input  logic                  clk,
    input  logic                  reset,
    input  logic                  out_en,
    input  logic [DATA_WIDTH-1:0] out_data,
    output logic                  m_valid,
    output logic [DATA_WIDTH-1:0] m_data,
    input  logic                  m_ready,
    output logic [ADDR_W:0]       count,
    output logic                  full,
    output logic                  empty,
    output logic                  overflow,
    output logic [7:0]            drop_cnt,
    input  logic                  clr_overflow
);

    localparam logic [ADDR_W:0] FullCount = (ADDR_W + 1)'(DEPTH);

    logic [DATA_WIDTH-1:0] mem [DEPTH];
    logic [ADDR_W-1:0]     wrPtr;
    logic [ADDR_W-1:0]     rdPtr;
    logic                  push;
    logic                  pop;
    logic                  accept;
    logic                  drop;

    assign full    = (count == FullCount);
    assign empty   = (count == '0);
    assign m_valid = ~empty;
    assign m_data  = m_valid ? mem[rdPtr] : '0;

    assign push   = out_en;
    assign pop    = m_valid & m_ready;
    // A pop in the same cycle frees the slot the incoming word lands in.
    assign accept = push & (~full | pop);
    assign drop   = push & full & ~pop;

    // Storage has no reset, but a word offered during reset must not land.
    always_ff @(posedge clk) begin
        if (reset && accept) begin
            mem[wrPtr] <= out_data;
        end
    end

    always_ff @(posedge clk) begin
        if (!reset) begin
            wrPtr    <= '0;
            rdPtr    <= '0;
            count    <= '0;
            overflow <= 1'b0;
            drop_cnt <= '0;
        end else begin
            if (accept) wrPtr <= wrPtr + ADDR_W'(1);
            if (pop)    rdPtr <= rdPtr + ADDR_W'(1);

            case ({accept, pop})
                2'b10:   count <= count + (ADDR_W + 1)'(1);
                2'b01:   count <= count - (ADDR_W + 1)'(1);
                default: count <= count;
            endcase

            // A drop in the clearing cycle still has to be reported.
            if (drop) begin
                overflow <= 1'b1;
                if (clr_overflow)            drop_cnt <= 8'd1;
                else if (drop_cnt != 8'hFF)  drop_cnt <= drop_cnt + 8'd1;
            end else if (clr_overflow) begin
                overflow <= 1'b0;
                drop_cnt <= '0;
            end
        end
    end

endmodule

// File: tb/tb_out_port_listener.sv
// Directed-vector bench for out_port_listener: one task per scenario, inline checks.
module tb_out_port_listener;

    logic        clk = 1'b0;
    logic        reset = 1'b0;
    logic        out_en = 1'b0;
    logic [15:0] out_data = '0;
    logic        m_valid;
    logic [15:0] m_data;
    logic        m_ready = 1'b0;
    logic [3:0]  count;
    logic        full;
    logic        empty;
    logic        overflow;
    logic [7:0]  drop_cnt;
    logic        clr_overflow = 1'b0;

    int checks = 0;
    int failures = 0;

    out_port_listener #(.DATA_WIDTH(16), .DEPTH(8), .ADDR_W(3)) dut (
        .clk(clk), .reset(reset), .out_en(out_en), .out_data(out_data),
        .m_valid(m_valid), .m_data(m_data), .m_ready(m_ready),
        .count(count), .full(full), .empty(empty), .overflow(overflow),
        .drop_cnt(drop_cnt), .clr_overflow(clr_overflow)
    );

    always #5 clk = ~clk;

    // Advance one rising edge; outputs are sampled 1 time unit later.
    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic do_reset();
        reset = 1'b0; out_en = 1'b0; m_ready = 1'b0; clr_overflow = 1'b0;
        step();
        reset = 1'b1;
    endtask

    task automatic push_word(input logic [15:0] d);
        out_en = 1'b1; out_data = d;
        step();
        out_en = 1'b0;
    endtask

    task automatic test_reset();
        do_reset();
        checks++; if (m_valid !== 1'b0) begin failures++; $display("FAIL rst_valid got=%b exp=0", m_valid); end
        checks++; if (m_data !== 16'h0) begin failures++; $display("FAIL rst_data got=%h exp=0000", m_data); end
        checks++; if (empty !== 1'b1) begin failures++; $display("FAIL rst_empty got=%b exp=1", empty); end
        checks++; if (full !== 1'b0) begin failures++; $display("FAIL rst_full got=%b exp=0", full); end
        checks++; if (count !== 4'd0) begin failures++; $display("FAIL rst_count got=%0d exp=0", count); end
        checks++; if ({overflow, drop_cnt} !== 9'h0) begin failures++; $display("FAIL rst_ovf got=%b/%0d exp=0/0", overflow, drop_cnt); end
    endtask

    task automatic test_single();
        push_word(16'hA5A5);
        checks++; if (m_valid !== 1'b1) begin failures++; $display("FAIL single_valid got=%b exp=1", m_valid); end
        checks++; if (m_data !== 16'hA5A5) begin failures++; $display("FAIL single_data got=%h exp=a5a5", m_data); end
        checks++; if (count !== 4'd1) begin failures++; $display("FAIL single_count got=%0d exp=1", count); end
        m_ready = 1'b1; step(); m_ready = 1'b0;
        checks++; if (m_valid !== 1'b0) begin failures++; $display("FAIL single_pop_valid got=%b exp=0", m_valid); end
        checks++; if (m_data !== 16'h0) begin failures++; $display("FAIL single_pop_data got=%h exp=0000", m_data); end
        checks++; if (empty !== 1'b1) begin failures++; $display("FAIL single_pop_empty got=%b exp=1", empty); end
    endtask

    task automatic test_no_bypass();
        // Push into empty with m_ready high: nothing may pop in that cycle.
        out_en = 1'b1; out_data = 16'h1234; m_ready = 1'b1;
        step();
        out_en = 1'b0; m_ready = 1'b0;
        checks++; if (count !== 4'd1 || m_data !== 16'h1234) begin failures++; $display("FAIL no_bypass got=%0d/%h exp=1/1234", count, m_data); end
        m_ready = 1'b1; step(); m_ready = 1'b0;
    endtask

    task automatic test_fill_overflow();
        for (int i = 1; i <= 8; i++) push_word(16'(i));
        checks++; if (full !== 1'b1 || count !== 4'd8) begin failures++; $display("FAIL fill_full got=%b/%0d exp=1/8", full, count); end
        push_word(16'h0009);
        checks++; if (overflow !== 1'b1 || drop_cnt !== 8'd1) begin failures++; $display("FAIL fill_drop got=%b/%0d exp=1/1", overflow, drop_cnt); end
        checks++; if (count !== 4'd8) begin failures++; $display("FAIL fill_drop_count got=%0d exp=8", count); end
        for (int i = 1; i <= 8; i++) begin
            checks++; if (m_valid !== 1'b1 || m_data !== 16'(i)) begin failures++; $display("FAIL fill_drain[%0d] got=%b/%h exp=1/%h", i, m_valid, m_data, 16'(i)); end
            m_ready = 1'b1; step(); m_ready = 1'b0;
        end
        checks++; if (empty !== 1'b1) begin failures++; $display("FAIL fill_empty got=%b exp=1", empty); end
        clr_overflow = 1'b1; step(); clr_overflow = 1'b0;
        checks++; if (overflow !== 1'b0 || drop_cnt !== 8'd0) begin failures++; $display("FAIL fill_clr got=%b/%0d exp=0/0", overflow, drop_cnt); end
    endtask

    task automatic test_full_push_pop();
        for (int i = 1; i <= 8; i++) push_word(16'h0010 + 16'(i));
        out_en = 1'b1; out_data = 16'h00FF; m_ready = 1'b1;
        step();
        out_en = 1'b0; m_ready = 1'b0;
        checks++; if (count !== 4'd8 || full !== 1'b1) begin failures++; $display("FAIL fpp_count got=%0d exp=8", count); end
        checks++; if (overflow !== 1'b0 || drop_cnt !== 8'd0) begin failures++; $display("FAIL fpp_nodrop got=%b/%0d exp=0/0", overflow, drop_cnt); end
        for (int i = 2; i <= 9; i++) begin
            logic [15:0] exp;
            exp = (i == 9) ? 16'h00FF : 16'h0010 + 16'(i);
            checks++; if (m_data !== exp) begin failures++; $display("FAIL fpp_drain[%0d] got=%h exp=%h", i, m_data, exp); end
            m_ready = 1'b1; step(); m_ready = 1'b0;
        end
        checks++; if (empty !== 1'b1) begin failures++; $display("FAIL fpp_empty got=%b exp=1", empty); end
    endtask

    task automatic test_stream();
        int got;
        got = 0;
        m_ready = 1'b1;
        for (int i = 0; i < 40; i++) begin
            if (i < 20) begin out_en = 1'b1; out_data = 16'(i); end
            else out_en = 1'b0;
            if (m_valid) begin
                checks++; if (m_data !== 16'(got)) begin failures++; $display("FAIL stream[%0d] got=%h exp=%h", got, m_data, 16'(got)); end
                got++;
            end
            step();
            if (i >= 20 && empty) break;
        end
        out_en = 1'b0; m_ready = 1'b0;
        checks++; if (got != 20) begin failures++; $display("FAIL stream_total got=%0d exp=20", got); end
        checks++; if (empty !== 1'b1) begin failures++; $display("FAIL stream_empty got=%b exp=1", empty); end
    endtask

    task automatic test_saturate();
        for (int i = 0; i < 8; i++) push_word(16'h0100 + 16'(i));
        out_en = 1'b1; out_data = 16'hDEAD;
        repeat (300) step();
        checks++; if (drop_cnt !== 8'd255 || overflow !== 1'b1) begin failures++; $display("FAIL sat_cnt got=%b/%0d exp=1/255", overflow, drop_cnt); end
        clr_overflow = 1'b1;
        step();
        checks++; if (overflow !== 1'b1 || drop_cnt !== 8'd1) begin failures++; $display("FAIL sat_clr_drop got=%b/%0d exp=1/1", overflow, drop_cnt); end
        out_en = 1'b0;
        step();
        clr_overflow = 1'b0;
        checks++; if (overflow !== 1'b0 || drop_cnt !== 8'd0) begin failures++; $display("FAIL sat_clr got=%b/%0d exp=0/0", overflow, drop_cnt); end
        checks++; if (count !== 4'd8 || m_data !== 16'h0100) begin failures++; $display("FAIL sat_contents got=%0d/%h exp=8/0100", count, m_data); end
    endtask

    task automatic test_reset_mid();
        do_reset();
        for (int i = 0; i < 8; i++) push_word(16'h0200 + 16'(i));
        push_word(16'h0208);
        m_ready = 1'b1; repeat (3) step(); m_ready = 1'b0;
        checks++; if (count !== 4'd5 || overflow !== 1'b1) begin failures++; $display("FAIL mid_setup got=%0d/%b exp=5/1", count, overflow); end
        reset = 1'b0; out_en = 1'b1; out_data = 16'hBEEF;
        step();
        reset = 1'b1; out_en = 1'b0;
        checks++; if (count !== 4'd0 || m_valid !== 1'b0 || m_data !== 16'h0) begin failures++; $display("FAIL mid_fifo got=%0d/%b/%h exp=0/0/0000", count, m_valid, m_data); end
        checks++; if (overflow !== 1'b0 || drop_cnt !== 8'd0) begin failures++; $display("FAIL mid_ovf got=%b/%0d exp=0/0", overflow, drop_cnt); end
        push_word(16'h0C0C);
        checks++; if (count !== 4'd1 || m_data !== 16'h0C0C) begin failures++; $display("FAIL mid_after got=%0d/%h exp=1/0c0c", count, m_data); end
    endtask

    initial begin
        test_reset();
        test_single();
        test_no_bypass();
        test_fill_overflow();
        test_full_push_pop();
        test_stream();
        test_saturate();
        test_reset_mid();
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule

// File: doc/out_port_listener.md
Name: out_port_listener

Overview:
Receiving end of the processor's output port. It samples outPortData every cycle outSignalEn is high and buffers each word in a small FIFO. It drains the FIFO to a downstream consumer over a valid/ready handshake. Lost words are reported through a sticky overflow flag and a saturating drop counter.

Parameters:
DATA_WIDTH, 16, width of one output-port word (matches outPortData)
DEPTH, 8, FIFO entries; power of two, minimum 2
ADDR_W, 3, log2(DEPTH)

Ports:
clk  input  1  system clock; all state updates on rising edge
reset  input  1  synchronous, active-low reset (0 = reset)
out_en  input  1  processor outSignalEn; one word per high cycle
out_data  input  DATA_WIDTH  processor outPortData; sampled when out_en=1
m_valid  output  1  head word available downstream
m_data  output  DATA_WIDTH  head word
m_ready  input  1  consumer accepts head when m_valid=1
count  output  ADDR_W+1  current occupancy, 0..DEPTH
full  output  1  count==DEPTH
empty  output  1  count==0
overflow  output  1  sticky; a word was dropped
drop_cnt  output  8  number of dropped words, saturates at 255
clr_overflow  input  1  clears overflow and drop_cnt

Behaviour:
- Reset (reset=0 at a rising edge): wr_ptr=0, rd_ptr=0, count=0, overflow=0, drop_cnt=0. Resulting outputs: m_valid=0, m_data=0, empty=1, full=0.
- Reset has priority over every other input. Reset mid-stream discards all buffered words.
- Storage array is not reset.
- Push: push = out_en. Each high cycle is an independent word; back-to-back high cycles give back-to-back words. No edge detection.
- Pop: pop = m_valid & m_ready. m_ready while m_valid=0 is ignored.
- Outputs are first-word-fall-through:
  - m_valid = ~empty.
  - m_data = mem[rd_ptr] when m_valid=1, else 0 (gated, never X).
- Write latency: a word pushed at edge N is visible on m_valid/m_data after edge N.
- There is no same-cycle bypass: push into an empty FIFO plus m_ready=1 in the same cycle pops nothing.
- Pointers wrap modulo DEPTH.
- count is registered: +1 on push only, -1 on pop only, unchanged on both or neither.
- full and empty are decoded from count.
- Push while full:
  - If pop is also asserted that cycle, the push is accepted; count stays DEPTH and the new word goes into the freed slot.
  - If no pop, the word is dropped; no pointer or storage change. overflow<=1 and drop_cnt<=min(drop_cnt+1,255).
- clr_overflow=1 sets overflow<=0 and drop_cnt<=0.
  - If a drop occurs in the same cycle, the drop wins: overflow<=1, drop_cnt<=1.
  - clr_overflow does not affect the FIFO contents.
- Ordering is strictly FIFO. Every accepted word is delivered exactly once.
- out_data is don't-care when out_en=0.

Test Plan:
1. Reset, then out_en=1 for one cycle with out_data=16'hA5A5, m_ready=0 -> next cycle m_valid=1, m_data=16'hA5A5, count=1. Then m_ready=1 for one cycle -> m_valid=0, m_data=0, empty=1.
2. 8 back-to-back pushes 16'h0001..16'h0008 with m_ragged ready=0 -> full=1, count=8. Then a 9th push 16'h0009 -> overflow=1, drop_cnt=1. Draining yields exactly 0001..0008 in order.
3. Full FIFO; push 16'h00FF and m_ready=1 in the same cycle -> count stays 8, no drop, 16'h00FF is read last after 7 further pops.
4. Continuous push and pop for 20 cycles with data 0..19 -> both pointers wrap at least twice, and the output sequence is 0..19 with no gaps.
5. Hold full with out_en=1 for 300 cycles -> drop_cnt saturates at 255. Then clr_overflow=1 in a cycle with a drop -> overflow=1, drop_cnt=1. Then clr_overflow=1 with no drop -> overflow=0, drop_cnt=0.
6. With 5 words buffered and overflow=1, drive reset=0 for one edge while out_en=1 -> count=0, m_valid=0, overflow=0, drop_cnt=0, and the pushed word is not stored.
